// File: rtl/tx_fifo_w2n_pkg.sv
// Shared constants and width helpers for the 128->8 transmit FIFO.
package tx_fifo_pkg;

    // Bytes per stored word and width of the byte index within a word
    localparam int unsigned RATIO = 16;
    localparam int unsigned IDX_W = $clog2(RATIO);

    // Word pointers carry one extra bit so full and empty are distinguishable
    function automatic int unsigned ptr_w(input int unsigned depth_w);
        return depth_w + 1;
    endfunction

    // Byte level spans 0 .. (2^depth_w * RATIO) inclusive
    function automatic int unsigned lvl_w(input int unsigned depth_w);
        return depth_w + 1 + IDX_W;
    endfunction

endpackage

// File: rtl/tx_fifo_w2n_if.sv
// Write/read handshake bundle for the transmit FIFO.
interface tx_fifo_w2n_if #(
    parameter int unsigned WR_DATA_WIDTH  = 128,
    parameter int unsigned RD_DATA_WIDTH  = 8,
    parameter int unsigned WR_DEPTH_WIDTH = 8
);
    import tx_fifo_pkg::*;

    logic                                   wr_en;
    logic [WR_DATA_WIDTH-1:0]               wr_data;
    logic                                   wr_full;
    logic                                   almost_full;
    logic                                   rd_en;
    logic [RD_DATA_WIDTH-1:0]               rd_data;
    logic                                   rd_empty;
    logic                                   almost_empty;
    logic [lvl_w(WR_DEPTH_WIDTH)-1:0]       rd_byte_level;

    // Bus/transmitter side
    modport master (
        output wr_en, wr_data, rd_en,
        input  wr_full, almost_full, rd_data, rd_empty, almost_empty, rd_byte_level
    );

    // FIFO side
    modport slave (
        input  wr_en, wr_data, rd_en,
        output wr_full, almost_full, rd_data, rd_empty, almost_empty, rd_byte_level
    );

endinterface

// File: rtl/tx_fifo_w2n_sdpram.sv
// Simple dual-port RAM with registered read; a same-address write is bypassed
// to the read output so a word is visible the cycle after it is written.
module tx_fifo_sdpram #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-port source: new data on collision, stored data otherwise
    always_comb begin
        rdata_d = mem[raddr];
        if (we && (waddr == raddr)) begin
            rdata_d = wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/tx_fifo_w2n.sv
// Width-down-converting transmit FIFO: 128-bit words in, bytes out LSB first.
module tx_fifo_w2n
    import tx_fifo_pkg::*;
#(
    parameter int unsigned WR_DATA_WIDTH    = 128,
    parameter int unsigned RD_DATA_WIDTH    = 8,
    parameter int unsigned WR_DEPTH_WIDTH   = 8,
    parameter int unsigned ALMOST_FULL_NUM  = 255,
    parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
    input  logic          clk,
    input  logic          rst,
    tx_fifo_w2n_if.slave  bus
);

    localparam int unsigned PTR_W = ptr_w(WR_DEPTH_WIDTH);
    localparam int unsigned LVL_W = lvl_w(WR_DEPTH_WIDTH);
    localparam logic [PTR_W-1:0] FULL_WORDS = {1'b1, {WR_DEPTH_WIDTH{1'b0}}};
    localparam logic [PTR_W-1:0] AF_WORDS   = PTR_W'(ALMOST_FULL_NUM);
    localparam logic [LVL_W-1:0] AE_BYTES   = LVL_W'(ALMOST_EMPTY_NUM);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(RATIO - 1);

    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]          rd_idx_q, rd_idx_d;
    logic [RD_DATA_WIDTH-1:0]  rd_data_q, rd_data_d;

    logic [PTR_W-1:0]          words;
    logic [LVL_W-1:0]          bytes;
    logic                      full, empty, wr_acc, rd_acc;
    logic [WR_DEPTH_WIDTH-1:0] ram_raddr;
    logic [WR_DATA_WIDTH-1:0]  ram_rdata;
    logic [RD_DATA_WIDTH-1:0]  ram_bytes [RATIO];

    // Occupancy and flags from registered state only
    always_comb begin
        words  = wr_ptr_q - rd_ptr_q;
        bytes  = {words, {IDX_W{1'b0}}} - LVL_W'(rd_idx_q);
        full   = (words == FULL_WORDS);
        empty  = (bytes == '0);
        wr_acc = bus.wr_en && !full;
        rd_acc = bus.rd_en && !empty;
    end

    // Split the RAM output word into its bytes
    always_comb begin
        for (int unsigned i = 0; i < RATIO; i++) begin
            ram_bytes[i] = ram_rdata[i*RD_DATA_WIDTH +: RD_DATA_WIDTH];
        end
    end

    // Next pointers, byte index and output byte
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_idx_d  = rd_idx_q;
        rd_data_d = rd_data_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_data_d = ram_bytes[rd_idx_q];
            rd_idx_d  = rd_idx_q + 1'b1;
            if (rd_idx_q == LAST_IDX) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    // RAM is addressed with the upcoming read pointer (forced to 0 under reset)
    // so the current word already sits at the RAM output when a read arrives.
    always_comb begin
        ram_raddr = rst ? '0 : rd_ptr_d[WR_DEPTH_WIDTH-1:0];
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_idx_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_idx_q  <= rd_idx_d;
            rd_data_q <= rd_data_d;
        end
    end

    tx_fifo_sdpram #(
        .DATA_W (WR_DATA_WIDTH),
        .ADDR_W (WR_DEPTH_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q[WR_DEPTH_WIDTH-1:0]),
        .wdata (bus.wr_data),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign bus.wr_full       = full;
    assign bus.almost_full   = (words >= AF_WORDS);
    assign bus.rd_empty      = empty;
    assign bus.almost_empty  = (bytes <= AE_BYTES);
    assign bus.rd_byte_level = bytes;
    assign bus.rd_data       = rd_data_q;

endmodule
